// File: rtl/vecmac_pkg.sv
// Shared types and constants for the vector-MAC job scheduler.
package vecmac_pkg;

    // Scheduler FSM states; PAD is only reachable with the watchdog compiled in.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_GRANT  = 3'd1,
        ST_STREAM = 3'd2,
        ST_WAIT   = 3'd3,
        ST_RESP   = 3'd4,
        ST_PAD    = 3'd5
    } state_e;

    localparam int LANE_W   = 8;
    localparam int LANES    = 4;
    localparam int OPND_W   = LANE_W * LANES;
    localparam int NREQ_DEF = 4;

    // Requester index width; never below one bit.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int ID_W = id_width(NREQ_DEF);

endpackage

// File: rtl/vecmac_rr_arb.sv
// Combinational round-robin pick: first set request at or after the pointer,
// wrapping modulo NREQ. Returns one-hot grant, its index and an any-request flag.
module vecmac_rr_arb #(
    parameter int NREQ = 4,
    parameter int ID_W = 2
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [ID_W-1:0] ptr_i,
    output logic [NREQ-1:0] gnt_oh_o,
    output logic [ID_W-1:0] gnt_idx_o,
    output logic            any_o
);

    int              idx;
    logic [ID_W-1:0] idx_w;

    // Scan requesters starting at the pointer; the first hit wins.
    always_comb begin
        gnt_oh_o  = '0;
        gnt_idx_o = '0;
        any_o     = 1'b0;
        idx       = 0;
        idx_w     = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx   = (int'(ptr_i) + k) % NREQ;
            idx_w = idx[ID_W-1:0];
            if (!any_o && req_i[idx_w]) begin
                any_o          = 1'b1;
                gnt_oh_o[idx_w] = 1'b1;
                gnt_idx_o      = idx_w;
            end
        end
    end

endmodule

// File: rtl/vecmac_job_sched.sv
// Round-robin job scheduler in front of a shared int8 4-lane vector-MAC datapath.
// One dot-product job (BEATS operand beats) is in flight at a time; the final
// accumulator sum is returned with the owning requester's ID.
// Optional feature macro: VECMAC_WDOG_EN -- stall watchdog that pads an
// abandoned job with zero beats and flags the response with rsp_err.
//
// Handshakes: a requester beat transfers on a cycle where req_valid[i] and
// req_ready[i] are both 1; req_ready[i] never depends on anything but the
// grant, the FSM state and req_valid[i]. The response transfers on a cycle
// where rsp_valid and rsp_ready are both 1; rsp_valid/rsp_id/rsp_data/rsp_err
// hold steady until then.
module vecmac_job_sched
    import vecmac_pkg::*;
#(
    parameter int NREQ   = NREQ_DEF,
    parameter int BEATS  = 250,
    parameter int W_ACC  = 32,
    parameter int TO_CYC = 64
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  logic [NREQ*OPND_W-1:0]    req_a,
    input  logic [NREQ*OPND_W-1:0]    req_b,
    output logic                      dp_valid,
    output logic [OPND_W-1:0]         dp_a,
    output logic [OPND_W-1:0]         dp_b,
    input  logic [W_ACC-1:0]          dp_result,
    input  logic                      dp_res_valid,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [id_width(NREQ)-1:0] rsp_id,
    output logic [W_ACC-1:0]          rsp_data,
    output logic                      rsp_err,
    output logic                      busy,
    output state_e                    dbg_state
);

    localparam int               GID_W = id_width(NREQ);
    localparam int               CNT_W = $clog2(BEATS);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(BEATS - 1);

    // Elaboration-time parameter range guards.
    if (NREQ < 2 || NREQ > 8) begin : g_nreq_range
        $error("NREQ must be in 2..8");
    end
    if (BEATS < 2) begin : g_beats_range
        $error("BEATS must be >= 2");
    end
    if (TO_CYC < 1) begin : g_to_cyc_range
        $error("TO_CYC must be >= 1");
    end

    state_e              state_q;
    logic [GID_W-1:0]    gnt_q;
    logic [NREQ-1:0]     gnt_oh_q;
    logic [GID_W-1:0]    ptr_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                rsp_valid_q;
    logic [GID_W-1:0]    rsp_id_q;
    logic [W_ACC-1:0]    rsp_data_q;

    logic [NREQ-1:0]     arb_oh;
    logic [GID_W-1:0]    arb_idx;
    logic                arb_any;
    logic [GID_W-1:0]    ptr_next;

    logic                sel_valid;
    logic [OPND_W-1:0]   sel_a;
    logic [OPND_W-1:0]   sel_b;
    logic                accept;
    logic                last_beat;

`ifdef VECMAC_WDOG_EN
    localparam int               STALL_W    = $clog2(TO_CYC + 1);
    localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(TO_CYC - 1);
    logic [STALL_W-1:0]  stall_q;
    logic                abort_q;
    logic                rsp_err_q;
`endif

    vecmac_rr_arb #(
        .NREQ (NREQ),
        .ID_W (GID_W)
    ) u_arb (
        .req_i     (req_valid),
        .ptr_i     (ptr_q),
        .gnt_oh_o  (arb_oh),
        .gnt_idx_o (arb_idx),
        .any_o     (arb_any)
    );

    assign ptr_next = (arb_idx == GID_W'(NREQ - 1)) ? '0 : arb_idx + 1'b1;

    // Mux the granted requester's valid and operand slices.
    always_comb begin
        sel_valid = 1'b0;
        sel_a     = '0;
        sel_b     = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (GID_W'(i) == gnt_q) begin
                sel_valid = req_valid[i];
                sel_a     = req_a[i*OPND_W +: OPND_W];
                sel_b     = req_b[i*OPND_W +: OPND_W];
            end
        end
    end

    assign accept    = (state_q == ST_STREAM) && sel_valid;
    assign last_beat = (cnt_q == LAST);
    assign req_ready = accept ? gnt_oh_q : '0;

    // Datapath beats pass straight through; PAD injects zero beats.
`ifdef VECMAC_WDOG_EN
    assign dp_valid = accept || (state_q == ST_PAD);
`else
    assign dp_valid = accept;
`endif
    assign dp_a = accept ? sel_a : '0;
    assign dp_b = accept ? sel_b : '0;

    // Job FSM: grant, beat counting, result capture and response hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            gnt_q       <= '0;
            gnt_oh_q    <= '0;
            ptr_q       <= '0;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
`ifdef VECMAC_WDOG_EN
            stall_q     <= '0;
            abort_q     <= 1'b0;
            rsp_err_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (|req_valid) state_q <= ST_GRANT;
                end
                ST_GRANT: begin
                    // A requester that withdrew before the grant cycle just returns us to IDLE.
                    if (arb_any) begin
                        gnt_q    <= arb_idx;
                        gnt_oh_q <= arb_oh;
                        ptr_q    <= ptr_next;
                        cnt_q    <= '0;
                        state_q  <= ST_STREAM;
`ifdef VECMAC_WDOG_EN
                        stall_q  <= '0;
                        abort_q  <= 1'b0;
`endif
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_STREAM: begin
                    if (accept) begin
`ifdef VECMAC_WDOG_EN
                        stall_q <= '0;
`endif
                        if (last_beat) begin
                            cnt_q   <= '0;
                            state_q <= ST_WAIT;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
`ifdef VECMAC_WDOG_EN
                    else if (stall_q == STALL_LAST) begin
                        state_q <= ST_PAD;
                        abort_q <= 1'b1;
                    end else begin
                        stall_q <= stall_q + 1'b1;
                    end
`endif
                end
`ifdef VECMAC_WDOG_EN
                ST_PAD: begin
                    // Fill the remaining beats with zeros so the accumulator still sees BEATS.
                    if (last_beat) begin
                        cnt_q   <= '0;
                        state_q <= ST_WAIT;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
`endif
                ST_WAIT: begin
                    if (dp_res_valid) begin
                        rsp_data_q  <= dp_result;
                        rsp_id_q    <= gnt_q;
                        rsp_valid_q <= 1'b1;
`ifdef VECMAC_WDOG_EN
                        rsp_err_q   <= abort_q;
`endif
                        state_q     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign busy      = (state_q != ST_IDLE);
    assign dbg_state = state_q;
`ifdef VECMAC_WDOG_EN
    assign rsp_err   = rsp_err_q;
`else
    assign rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_vecmac_job_sched.sv
// Directed bench for vecmac_job_sched with a behavioural int8 4-lane
// accumulator standing in for the shared datapath.
module tb_vecmac_job_sched;
  import vecmac_pkg::*;

  localparam int NREQ   = 4;
  localparam int BEATS  = 250;
  localparam int W_ACC  = 32;
  localparam int TO_CYC = 64;

  logic              clk;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*32-1:0] req_a;
  logic [NREQ*32-1:0] req_b;
  logic              dp_valid;
  logic [31:0]       dp_a;
  logic [31:0]       dp_b;
  logic [W_ACC-1:0]  dp_result;
  logic              dp_res_valid;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [1:0]        rsp_id;
  logic [W_ACC-1:0]  rsp_data;
  logic              rsp_err;
  logic              busy;
  state_e            dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  // Datapath model and spurious-pulse injector.
  logic              spur_v;
  logic              m_valid;
  logic [W_ACC-1:0]  m_result;
  int                m_acc;
  int                m_cnt;

  // Passive monitors (free-running counters, never cleared).
  int                tot_beats  = 0;
  int                zero_beats = 0;
  int                bad_ready  = 0;
  logic [NREQ-1:0]   job_mask_cur;
  logic [NREQ-1:0]   job_mask_last;

  vecmac_job_sched #(
    .NREQ   (NREQ),
    .BEATS  (BEATS),
    .W_ACC  (W_ACC),
    .TO_CYC (TO_CYC)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_a        (req_a),
    .req_b        (req_b),
    .dp_valid     (dp_valid),
    .dp_a         (dp_a),
    .dp_b         (dp_b),
    .dp_result    (dp_result),
    .dp_res_valid (dp_res_valid),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_id       (rsp_id),
    .rsp_data     (rsp_data),
    .rsp_err      (rsp_err),
    .busy         (busy),
    .dbg_state    (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, required finish before time limit");
    $fatal(1, "global timeout");
  end

  // ---------------- datapath model ----------------
  function automatic int beat_sum(input logic [31:0] a, input logic [31:0] b);
    int s;
    s = 0;
    for (int l = 0; l < 4; l++) begin
      s += int'($signed(a[8*l +: 8])) * int'($signed(b[8*l +: 8]));
    end
    return s;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_acc    <= 0;
      m_cnt    <= 0;
      m_valid  <= 1'b0;
      m_result <= '0;
    end else begin
      m_valid <= 1'b0;
      if (dp_valid) begin
        if (m_cnt == BEATS - 1) begin
          m_result <= W_ACC'(m_acc + beat_sum(dp_a, dp_b));
          m_valid  <= 1'b1;
          m_acc    <= 0;
          m_cnt    <= 0;
        end else begin
          m_acc <= m_acc + beat_sum(dp_a, dp_b);
          m_cnt <= m_cnt + 1;
        end
      end
    end
  end

  assign dp_res_valid = m_valid | spur_v;
  assign dp_result    = spur_v ? 32'hDEAD_BEEF : m_result;

  // ---------------- monitors ----------------
  always @(posedge clk) begin
    if (dp_valid) tot_beats <= tot_beats + 1;
    if (dp_valid && dp_a == 32'h0 && dp_b == 32'h0) zero_beats <= zero_beats + 1;
    if (((req_ready & ~req_valid) != '0) || ($countones(req_ready) > 1)) bad_ready <= bad_ready + 1;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      job_mask_cur  <= '0;
      job_mask_last <= '0;
    end else if (rsp_valid && rsp_ready) begin
      job_mask_last <= job_mask_cur;
      job_mask_cur  <= '0;
    end else begin
      job_mask_cur <= job_mask_cur | req_ready;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b1;
    spur_v    = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b);
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
  endtask

  task automatic wait_rsp(input int max_cyc, output bit seen);
    seen = 1'b0;
    for (int c = 0; c < max_cyc && !seen; c++) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
  endtask

  // Count accepted beats of requester i until n are committed (last one accepts at the next edge).
  task automatic count_beats(input int i, input int n, output bit ok);
    int acc;
    acc = 0;
    ok  = 1'b0;
    for (int c = 0; c < 2000 && acc < n; c++) begin
      @(negedge clk);
      #1;
      if (req_ready[i]) acc++;
    end
    ok = (acc == n);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n     = 1'b0;
    req_valid = '1;
    rsp_ready = 1'b0;
    spur_v    = 1'b0;
    req_a     = '0;
    req_b     = '0;
    repeat (2) @(negedge clk);
    #1;
    n_tests++;
    if ({rsp_valid, rsp_err, busy, dp_valid} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_flags: got {rsp_valid,rsp_err,busy,dp_valid}=%b required 0000", {rsp_valid, rsp_err, busy, dp_valid});
    end
    n_tests++;
    if (req_ready !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_req_ready: got %b required 0000", req_ready);
    end
    n_tests++;
    if (rsp_data !== 32'h0 || rsp_id !== 2'd0 || dp_a !== 32'h0 || dp_b !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_buses: got data=%h id=%0d dp_a=%h dp_b=%h required all 0", rsp_data, rsp_id, dp_a, dp_b);
    end
    n_tests++;
    if (dbg_state !== ST_IDLE) begin
      n_fail++;
      $display("FAIL reset_state: got %0d required %0d", dbg_state, ST_IDLE);
    end
  endtask

  task automatic test_single();
    bit seen;
    int b0;
    do_reset();
    set_req(0, 32'h0101_0101, 32'h0101_0101);
    b0 = tot_beats;
    req_valid = 4'b0001;
    repeat (20) @(negedge clk);
    // Stray result pulse mid-stream must be ignored.
    spur_v = 1'b1;
    @(negedge clk);
    spur_v = 1'b0;
    #1;
    n_tests++;
    if (rsp_valid !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL single_spurious: got rsp_valid=%b busy=%b required rsp_valid=0 busy=1", rsp_valid, busy);
    end
    wait_rsp(600, seen);
    req_valid = 4'b0000;
    n_tests++;
    if (!seen) begin
      n_fail++;
      $display("FAIL single_timeout: got no rsp_valid required rsp_valid within 600 cycles");
    end
    n_tests++;
    if (rsp_id !== 2'd0 || rsp_data !== 32'd1000 || rsp_err !== 1'b0) begin
      n_fail++;
      $display("FAIL single_rsp: got id=%0d data=%0d err=%b required id=0 data=1000 err=0", rsp_id, rsp_data, rsp_err);
    end
    n_tests++;
    if (tot_beats - b0 !== 250) begin
      n_fail++;
      $display("FAIL single_beats: got %0d required 250", tot_beats - b0);
    end
    repeat (3) @(negedge clk);
    n_tests++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL single_idle: got rsp_valid=%b busy=%b required 0 0", rsp_valid, busy);
    end
  endtask

  task automatic test_round_robin();
    bit seen;
    int exp_id[5]  = '{0, 1, 2, 3, 0};
    int exp_sum[5] = '{1000, 2000, 3000, 4000, 1000};
    logic [3:0] exp_mask;
    int bad0;
    do_reset();
    bad0 = bad_ready;
    set_req(0, 32'h0101_0101, 32'h0101_0101);
    set_req(1, 32'h0202_0202, 32'h0101_0101);
    set_req(2, 32'h0303_0303, 32'h0101_0101);
    set_req(3, 32'h0404_0404, 32'h0101_0101);
    req_valid = 4'b1111;
    for (int j = 0; j < 5; j++) begin
      wait_rsp(600, seen);
      n_tests++;
      if (!seen || rsp_id !== 2'(exp_id[j]) || rsp_data !== 32'(exp_sum[j])) begin
        n_fail++;
        $display("FAIL rr_job%0d: got seen=%b id=%0d data=%0d required id=%0d data=%0d", j, seen, rsp_id, rsp_data, exp_id[j], exp_sum[j]);
      end
      @(negedge clk);
      exp_mask = 4'b0001 << exp_id[j];
      n_tests++;
      if (job_mask_last !== exp_mask) begin
        n_fail++;
        $display("FAIL rr_ready_mask%0d: got %b required %b", j, job_mask_last, exp_mask);
      end
    end
    n_tests++;
    if (bad_ready - bad0 !== 0) begin
      n_fail++;
      $display("FAIL rr_non_owner_ready: got %0d bad cycles required 0", bad_ready - bad0);
    end
    req_valid = 4'b0000;
  endtask

  task automatic test_bubble();
    bit ok;
    bit seen;
    int gap;
    int b0;
    do_reset();
    // lanes {a3..a0}={-1,2,-3,4}, {b3..b0}={5,6,7,8}: -5+12-21+32 = 18 per beat
    set_req(2, 32'hFF02_FD04, 32'h0506_0708);
    b0 = tot_beats;
    req_valid = 4'b0100;
    count_beats(2, 100, ok);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL bubble_first100: got fewer beats required 100 beats accepted");
    end
    gap = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      req_valid = 4'b0000;
      #1;
      if (!dp_valid) gap++;
    end
    @(negedge clk);
    req_valid = 4'b0100;
    #1;
    n_tests++;
    if (gap !== 10 || dp_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL bubble_gap: got gap=%0d resume=%b required gap=10 resume=1", gap, dp_valid);
    end
    wait_rsp(600, seen);
    req_valid = 4'b0000;
    n_tests++;
    if (!seen || rsp_id !== 2'd2 || rsp_data !== 32'd4500 || tot_beats - b0 !== 250) begin
      n_fail++;
      $display("FAIL bubble_rsp: got seen=%b id=%0d data=%0d beats=%0d required id=2 data=4500 beats=250", seen, rsp_id, rsp_data, tot_beats - b0);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_hold();
    bit seen;
    int bad;
    do_reset();
    set_req(0, 32'h0101_0101, 32'h0101_0101);
    set_req(1, 32'h0202_0202, 32'h0101_0101);
    rsp_ready = 1'b0;
    req_valid = 4'b0011;
    wait_rsp(600, seen);
    n_tests++;
    if (!seen || rsp_id !== 2'd0 || rsp_data !== 32'd1000) begin
      n_fail++;
      $display("FAIL hold_first: got seen=%b id=%0d data=%0d required id=0 data=1000", seen, rsp_id, rsp_data);
    end
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      #1;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== 32'd1000 || req_ready !== 4'b0000 || dp_valid !== 1'b0)
        bad++;
    end
    n_tests++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL hold_stable: got %0d unstable cycles required 0", bad);
    end
    @(negedge clk);
    req_valid = 4'b0010;
    rsp_ready = 1'b1;
    @(negedge clk);
    n_tests++;
    if (rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_release: got rsp_valid=%b required 0", rsp_valid);
    end
    wait_rsp(600, seen);
    req_valid = 4'b0000;
    n_tests++;
    if (!seen || rsp_id !== 2'd1 || rsp_data !== 32'd2000) begin
      n_fail++;
      $display("FAIL hold_second: got seen=%b id=%0d data=%0d required id=1 data=2000", seen, rsp_id, rsp_data);
    end
    @(negedge clk);
    n_tests++;
    if (job_mask_last !== 4'b0010) begin
      n_fail++;
      $display("FAIL hold_second_mask: got %b required 0010", job_mask_last);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit seen;
    // rsp_data still holds 2000 from the previous job here.
    set_req(0, 32'h0101_0101, 32'h0101_0101);
    req_valid = 4'b0001;
    count_beats(0, 57, ok);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (!ok || {rsp_valid, rsp_err, busy, dp_valid} !== 4'b0000 || req_ready !== 4'b0000) begin
      n_fail++;
      $display("FAIL rstmid_flags: got ok=%b flags=%b ready=%b required flags=0000 ready=0000", ok, {rsp_valid, rsp_err, busy, dp_valid}, req_ready);
    end
    n_tests++;
    if (rsp_data !== 32'h0 || rsp_id !== 2'd0 || dp_a !== 32'h0 || dbg_state !== ST_IDLE) begin
      n_fail++;
      $display("FAIL rstmid_buses: got data=%0d id=%0d dp_a=%h state=%0d required 0 0 0 IDLE", rsp_data, rsp_id, dp_a, dbg_state);
    end
    repeat (2) @(negedge clk);
    req_valid = 4'b0000;
    // 4 lanes of 3 * -1 = -12 per beat, -3000 per job
    set_req(3, 32'h0303_0303, 32'hFFFF_FFFF);
    rst_n = 1'b1;
    @(negedge clk);
    req_valid = 4'b1000;
    wait_rsp(600, seen);
    req_valid = 4'b0000;
    n_tests++;
    if (!seen || rsp_id !== 2'd3 || rsp_data !== 32'hFFFF_F448) begin
      n_fail++;
      $display("FAIL rstmid_next_job: got seen=%b id=%0d data=%h required id=3 data=fffff448", seen, rsp_id, rsp_data);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_stall();
    bit ok;
    bit seen;
    int z0;
    int stall;
    do_reset();
    set_req(0, 32'h0101_0101, 32'h0101_0101);
    req_valid = 4'b0001;
    count_beats(0, 30, ok);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL stall_first30: got fewer beats required 30 beats accepted");
    end
    z0 = zero_beats;
`ifdef VECMAC_WDOG_EN
    stall = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      req_valid = 4'b0000;
      #1;
      if (dp_valid) break;
      stall++;
    end
    n_tests++;
    if (stall !== TO_CYC) begin
      n_fail++;
      $display("FAIL wdog_stall_len: got %0d required %0d", stall, TO_CYC);
    end
    wait_rsp(800, seen);
    n_tests++;
    if (!seen || rsp_err !== 1'b1 || rsp_data !== 32'd120 || rsp_id !== 2'd0) begin
      n_fail++;
      $display("FAIL wdog_rsp: got seen=%b err=%b data=%0d id=%0d required err=1 data=120 id=0", seen, rsp_err, rsp_data, rsp_id);
    end
    n_tests++;
    if (zero_beats - z0 !== 220) begin
      n_fail++;
      $display("FAIL wdog_pad_beats: got %0d required 220", zero_beats - z0);
    end
`else
    stall = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      req_valid = 4'b0000;
      #1;
      if (dp_valid !== 1'b0 || busy !== 1'b1 || rsp_valid !== 1'b0) stall++;
    end
    n_tests++;
    if (stall !== 0 || zero_beats - z0 !== 0) begin
      n_fail++;
      $display("FAIL stall_wait: got %0d bad cycles, %0d pad beats required 0 0", stall, zero_beats - z0);
    end
    @(negedge clk);
    req_valid = 4'b0001;
    wait_rsp(600, seen);
    n_tests++;
    if (!seen || rsp_err !== 1'b0 || rsp_data !== 32'd1000 || rsp_id !== 2'd0) begin
      n_fail++;
      $display("FAIL stall_rsp: got seen=%b err=%b data=%0d id=%0d required err=0 data=1000 id=0", seen, rsp_err, rsp_data, rsp_id);
    end
`endif
    req_valid = 4'b0000;
    repeat (2) @(negedge clk);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_bubble();
    test_hold();
    test_reset_mid();
    test_stall();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
